hyp_rr_sched: RTL and testbench

- Time-shared hypotenuse engine: floor(sqrt(a²+b²)) for NUM_REQ independent requesters.
- Round-robin arbitration and a valid/ready handshake on every requester port.
- Multi-cycle bit-serial square root, so one small datapath replaces per-requester single-cycle squarers and roots.
- Sits between the input-capture logic and the output mux. Each result is returned with the ID of the requester that issued it.

---
 rtl/hyp_rr_sched_pkg.sv | 37 +++
 rtl/hyp_rr_sched_if.sv | 37 +++
 rtl/hyp_rr_sched_isqrt_seq.sv | 82 ++++++++
 rtl/hyp_rr_sched.sv | 139 +++++++++++++
 tb/tb_hyp_rr_sched.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hyp_rr_sched_pkg.sv
// hyp_pkg: shared types and width helpers for the time-shared hypotenuse engine.
//   state_t    : controller states (IDLE, SQUARE, ROOT, DONE)
//   res_width  : result width for operand width w (w+1)
//   sum_width  : width of a*a+b*b without truncation (2w+1)
//   clog2      : ceiling log2
//   id_width   : requester ID width, never narrower than 1 bit
package hyp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        ROOT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int res_width(input int w);
        return w + 32'sd1;
    endfunction

    function automatic int sum_width(input int w);
        return (32'sd2 * w) + 32'sd1;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    function automatic int id_width(input int n);
        return (n < 32'sd2) ? 32'sd1 : clog2(n);
    endfunction

endpackage

// File: rtl/hyp_rr_sched_if.sv
// hyp_rr_sched_if: requester and response bundle of the hypotenuse engine.
//   req_valid/req_a/req_b : per-requester strobes and packed operands (slot i at [i*W +: W])
//   req_ready             : one-hot grant back to the requesters
//   rsp_valid/rsp_ready   : result handshake
//   rsp_id/rsp_data       : served requester index and floor(sqrt(a*a+b*b))
//   busy                  : engine is working on or holding a job
// master: the requester/consumer side; slave: the engine.
interface hyp_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8
);
    import hyp_pkg::*;

    localparam int RES_W = res_width(W);
    localparam int ID_W  = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [RES_W-1:0]     rsp_data;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/hyp_rr_sched_isqrt_seq.sv
// hyp_isqrt_seq: restoring bit-serial integer square root, one result bit per
// clock, MSB first, W+1 iterations.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : first iteration uses sum directly, so no separate load cycle
//   sum        : radicand, 2W+1 bits
//   root       : floor(sqrt(sum)), W+1 bits, held until the next start
//   done       : high during the cycle whose clock edge completes the root
module hyp_isqrt_seq
    import hyp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2*W:0] sum,
    output logic [W:0]   root,
    output logic         done
);

    localparam int RES_W = res_width(W);
    localparam int PAD_W = 2 * RES_W;      // radicand padded to an even bit count
    localparam int REM_W = RES_W + 2;      // partial remainder plus two shifted-in bits
    localparam int CNT_W = clog2(RES_W) + 1;

    logic [PAD_W-1:0] sh_r, src_sh_s, sh_nx_s;
    logic [REM_W-1:0] rem_r, src_rem_s, rem_sh_s, trial_s, rem_nx_s;
    logic [RES_W-1:0] root_r, src_root_s, root_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic             active_r;

    // One restoring step: bring down two radicand bits, keep the trial bit if it fits.
    always_comb begin
        if (start) begin
            src_sh_s   = {1'b0, sum};
            src_rem_s  = '0;
            src_root_s = '0;
        end else begin
            src_sh_s   = sh_r;
            src_rem_s  = rem_r;
            src_root_s = root_r;
        end
        // The top two remainder bits are always zero here, so the truncation is lossless.
        rem_sh_s = REM_W'({src_rem_s, src_sh_s[PAD_W-1 -: 2]});
        trial_s  = {src_root_s, 2'b01};
        sh_nx_s  = {src_sh_s[PAD_W-3:0], 2'b00};
        if (rem_sh_s >= trial_s) begin
            rem_nx_s  = rem_sh_s - trial_s;
            root_nx_s = RES_W'({src_root_s, 1'b1});
        end else begin
            rem_nx_s  = rem_sh_s;
            root_nx_s = RES_W'({src_root_s, 1'b0});
        end
    end

    // Iteration registers and counter; start performs iteration 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r     <= '0;
            rem_r    <= '0;
            root_r   <= '0;
            cnt_r    <= '0;
            active_r <= 1'b0;
        end else if (start) begin
            sh_r     <= sh_nx_s;
            rem_r    <= rem_nx_s;
            root_r   <= root_nx_s;
            cnt_r    <= CNT_W'(1);
            active_r <= 1'b1;
        end else if (active_r) begin
            sh_r     <= sh_nx_s;
            rem_r    <= rem_nx_s;
            root_r   <= root_nx_s;
            cnt_r    <= cnt_r + CNT_W'(1);
            active_r <= (cnt_r != CNT_W'(RES_W - 1));
        end
    end

    assign root = root_r;
    assign done = active_r && (cnt_r == CNT_W'(RES_W - 1));

endmodule

// File: rtl/hyp_rr_sched.sv
// hyp_rr_sched: round-robin scheduled floor(sqrt(a*a+b*b)) engine shared by
// NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any job in flight)
//   bus        : hyp_rr_sched_if.slave -- request strobes/operands, one-hot
//                grant, result handshake with ID and data, busy
// Flow: IDLE grants one requester and captures its operands, SQUARE registers
// a*a+b*b at full width, ROOT runs W+1 serial root steps, DONE holds the result
// until the consumer takes it.
module hyp_rr_sched
    import hyp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    hyp_rr_sched_if.slave bus
);

    localparam int RES_W = res_width(W);
    localparam int SUM_W = sum_width(W);
    localparam int ID_W  = id_width(NUM_REQ);

    state_t             state_r, next_state_s;
    logic [ID_W-1:0]    ptr_r;          // index where the next priority search begins
    logic [ID_W-1:0]    id_r;
    logic [ID_W-1:0]    grant_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               found_s;
    logic [W-1:0]       a_r, b_r;
    logic [SUM_W-1:0]   sum_s, sum_r;
    logic               start_r;
    logic [RES_W-1:0]   root_s;
    logic               root_done_s;

    // Rotating index base+k wrapped into 0..NUM_REQ-1 (k < NUM_REQ).
    function automatic int rr_index(input int base, input int k);
        int s;
        s = base + k;
        return (s >= NUM_REQ) ? (s - NUM_REQ) : s;
    endfunction

    // Round-robin search from ptr_r; grants only in IDLE and only to a valid requester.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        found_s     = 1'b0;
        if (state_r == IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found_s && bus.req_valid[rr_index(int'(ptr_r), k)]) begin
                    found_s     = 1'b1;
                    grant_idx_s = ID_W'(rr_index(int'(ptr_r), k));
                end else begin
                    found_s     = found_s;
                end
            end
            if (found_s) begin
                grant_s[grant_idx_s] = 1'b1;
            end else begin
                grant_s = '0;
            end
        end else begin
            grant_s = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) next_state_s = SQUARE;
                else         next_state_s = IDLE;
            end
            SQUARE: next_state_s = ROOT;
            ROOT: begin
                if (root_done_s) next_state_s = DONE;
                else             next_state_s = ROOT;
            end
            DONE: begin
                if (bus.rsp_ready) next_state_s = IDLE;
                else               next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Operand/ID capture on acceptance; the search pointer moves past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
            id_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else if (found_s) begin
            id_r  <= grant_idx_s;
            ptr_r <= (grant_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : (grant_idx_s + ID_W'(1));
            a_r   <= bus.req_a[int'(grant_idx_s) * W +: W];
            b_r   <= bus.req_b[int'(grant_idx_s) * W +: W];
        end
    end

    assign sum_s = (SUM_W'(a_r) * SUM_W'(a_r)) + (SUM_W'(b_r) * SUM_W'(b_r));

    // Full-width sum register, plus the root start pulse for the first ROOT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= '0;
            start_r <= 1'b0;
        end else begin
            start_r <= (state_r == SQUARE);
            if (state_r == SQUARE) sum_r <= sum_s;
        end
    end

    hyp_isqrt_seq #(
        .W (W)
    ) u_isqrt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_r),
        .sum   (sum_r),
        .root  (root_s),
        .done  (root_done_s)
    );

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = (state_r == DONE);
    assign bus.rsp_id    = id_r;
    assign bus.rsp_data  = root_s;
    assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_hyp_rr_sched.sv
// Self-checking bench for hyp_rr_sched (NUM_REQ=4, W=8). Expected results come
// from an integer square-root search and the round-robin rule, both kept here.
module tb_hyp_rr_sched;

    localparam int NREQ = 4;
    localparam int OPW  = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   exp_grant_q[$];
    int   exp_id_q[$];
    int   exp_data_q[$];

    hyp_rr_sched_if #(.NUM_REQ(NREQ), .W(OPW)) bus ();

    hyp_rr_sched #(.NUM_REQ(NREQ), .W(OPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int isqrt_ref(input int s);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated job: a,b offered, a2,b2 driven right after acceptance,
    // rsp_ready held low for 'hold' cycles once the result shows up.
    task automatic run_job(input int id, input int a, input int b, input int a2,
                           input int b2, input int hold, input string tag);
        int n;
        int lat;
        int expd;
        expd = isqrt_ref(a * a + b * b);
        @(negedge clk);
        bus.req_valid = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_a[id*OPW +: OPW] = OPW'(a);
        bus.req_b[id*OPW +: OPW] = OPW'(b);
        bus.rsp_ready = (hold == 0);
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_grant"}, bus.req_ready, 32'd1 << id);
        @(negedge clk); #1;
        check({tag, "_grant_one_cycle"}, bus.req_ready, 0);
        check({tag, "_busy"}, bus.busy, 1);
        bus.req_valid = '0;
        bus.req_a[id*OPW +: OPW] = OPW'(a2);
        bus.req_b[id*OPW +: OPW] = OPW'(b2);
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk); #1; lat++;
        end
        check({tag, "_latency"}, lat, 10);
        check({tag, "_id"}, bus.rsp_id, id);
        check({tag, "_data"}, bus.rsp_data, expd);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            check({tag, "_hold_valid"}, bus.rsp_valid, 1);
            check({tag, "_hold_data"}, bus.rsp_data, expd);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_valid_after"}, bus.rsp_valid, 0);
    endtask

    // Watches grants and responses against the expected queues. Called at a
    // negedge right after the requests were set up; one_shot drops a
    // requester's valid once its grant has been accepted.
    task automatic collect(input int n_rsp, input bit one_shot);
        int got;
        int cyc;
        int last;
        int gi;
        logic [NREQ-1:0] pend;
        got = 0; cyc = 0; last = -1; pend = '0;
        while (got < n_rsp && cyc < 400) begin
            #1;
            if (bus.req_ready != '0) begin
                check("grant_onehot", $countones(bus.req_ready), 1);
                if (exp_grant_q.size() > 0) gi = exp_grant_q.pop_front();
                else gi = 99;
                check("grant_order", bus.req_ready, (gi < 32) ? (32'd1 << gi) : 32'd0);
                if (last >= 0) check("grant_gap_ge_12", ((cyc - last) >= 12), 1);
                last = cyc;
                if (one_shot) pend = bus.req_ready;
            end
            if (bus.rsp_valid) begin
                check("rsp_id", bus.rsp_id, exp_id_q.pop_front());
                check("rsp_data", bus.rsp_data, exp_data_q.pop_front());
                got++;
            end
            @(negedge clk);
            cyc++;
            bus.req_valid = bus.req_valid & ~pend;
            pend = '0;
        end
        check("rsp_count", got, n_rsp);
    endtask

    initial begin
        int id, a, b, lat, seen, expd;
        logic [31:0] held_id, held_data;
        clk = 1'b0; rst_n = 1'b0; checks = 0; failures = 0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_no_grant", bus.req_ready, 0);

        // Directed jobs and boundaries
        run_job(2, 3, 4, 3, 4, 0, "single");
        run_job(0, 255, 255, 255, 255, 0, "max");
        run_job(0, 0, 0, 0, 0, 0, "zero");
        run_job(0, 1, 1, 1, 1, 0, "ones");
        run_job(0, 0, 200, 0, 200, 0, "b_only");
        run_job(0, 6, 8, 1, 1, 0, "opchg");

        // Randomized isolated jobs with random backpressure and operand churn
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(0, NREQ - 1), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), "rand");
        end

        // All requesters valid continuously from reset: rotating service
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_grant_q.push_back(i % NREQ);
            exp_id_q.push_back(i % NREQ);
            exp_data_q.push_back(isqrt_ref(((i % NREQ) + 1) * ((i % NREQ) + 1)));
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*OPW +: OPW] = OPW'(i + 1);
            bus.req_b[i*OPW +: OPW] = '0;
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        collect(8, 1'b0);
        bus.req_valid = '0;

        // Backpressure in DONE with another request pending
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_a[1*OPW +: OPW] = 8'd20; bus.req_b[1*OPW +: OPW] = 8'd21;
        bus.req_a[3*OPW +: OPW] = 8'd5;  bus.req_b[3*OPW +: OPW] = 8'd12;
        bus.req_valid = 4'b0010;
        #1;
        lat = 0;
        while (bus.req_ready == '0 && lat < 40) begin @(negedge clk); #1; lat++; end
        check("bp_grant1", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin @(negedge clk); #1; lat++; end
        check("bp_id", bus.rsp_id, 1);
        check("bp_data", bus.rsp_data, isqrt_ref(20 * 20 + 21 * 21));
        held_id = 32'(bus.rsp_id);
        held_data = 32'(bus.rsp_data);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk); #1;
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_id", bus.rsp_id, held_id);
            check("bp_hold_data", bus.rsp_data, held_data);
            check("bp_no_grant", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_no_grant_on_handshake", bus.req_ready, 0);
        @(negedge clk); #1;
        check("bp_grant3_after", bus.req_ready, 4'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin @(negedge clk); #1; lat++; end
        check("bp2_latency", lat, 10);
        check("bp2_id", bus.rsp_id, 3);
        check("bp2_data", bus.rsp_data, isqrt_ref(5 * 5 + 12 * 12));
        @(negedge clk);

        // Reset while ROOT is in progress
        bus.req_a[2*OPW +: OPW] = 8'd9; bus.req_b[2*OPW +: OPW] = 8'd12;
        bus.req_valid = 4'b0100;
        #1;
        lat = 0;
        while (bus.req_ready == '0 && lat < 40) begin @(negedge clk); #1; lat++; end
        check("abort_grant", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        check("abort_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid) seen = 1;
        end
        check("abort_no_response", seen, 0);

        // Simultaneous requests after reset: 1 first, then 3
        @(negedge clk);
        bus.req_a[1*OPW +: OPW] = 8'd7;  bus.req_b[1*OPW +: OPW] = 8'd24;
        bus.req_a[3*OPW +: OPW] = 8'd100; bus.req_b[3*OPW +: OPW] = 8'd33;
        exp_grant_q = {1, 3};
        exp_id_q = {1, 3};
        expd = isqrt_ref(100 * 100 + 33 * 33);
        exp_data_q = {isqrt_ref(7 * 7 + 24 * 24), expd};
        bus.req_valid = 4'b1010;
        collect(2, 1'b1);
        bus.req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
